// File: rtl/truth_table_capture_pkg.sv
// Shared definitions for the truth-table capture block: FSM encoding,
// default table width and the default expected word for s = (y|~z)&(~x|~z).
package truth_table_capture_pkg;

  localparam int DEFAULT_N_VARS = 3;
  localparam int TT_WIDTH       = 2 ** DEFAULT_N_VARS;

  // Bit m = s(m), with x as the MSB of m.
  localparam logic [TT_WIDTH-1:0] DEFAULT_EXPECTED = 8'h5D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/truth_table_capture_popcount_update.sv
// Next-value logic for the ones counter: advances by one when an accepted
// first-time sample carries s=1, otherwise holds.
module tt_popcount_update #(
  parameter int N_VARS = 3
) (
  input  logic [N_VARS:0] count,
  input  logic            inc,
  output logic [N_VARS:0] count_next
);

  // The counter is N_VARS+1 bits wide and can reach at most 2**N_VARS, so no wrap.
  assign count_next = inc ? (count + {{N_VARS{1'b0}}, 1'b1}) : count;

endmodule

// File: rtl/truth_table_capture.sv
// Assembles a 2**N_VARS-entry truth table from (minterm, value) samples,
// counts ones, flags completion and compares against EXPECTED.
// Optional first-mismatch log: define TT_CAPTURE_MISMATCH_LOG_EN.
//
// Handshake: a sample transfers on a rising edge where in_valid & in_ready
// and start is low; in_ready depends only on state, never on in_valid.
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int                     N_VARS   = DEFAULT_N_VARS,
  parameter logic [2**N_VARS-1:0]   EXPECTED = DEFAULT_EXPECTED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_VARS-1:0]     in_m,
  input  logic                  in_s,
  output logic [2**N_VARS-1:0]  tt_word,
  output logic [2**N_VARS-1:0]  seen_mask,
  output logic [N_VARS:0]       ones_count,
  output logic                  done,
  output logic                  match,
  output logic                  dup_err,
`ifdef TT_CAPTURE_MISMATCH_LOG_EN
  output logic [N_VARS-1:0]     first_bad_m,
  output logic                  first_bad_vld,
`endif
  output state_t                dbg_state
);

  localparam int TT_W = 2 ** N_VARS;

  state_t            state, state_next;
  logic              accept, new_sample, complete;
  logic [TT_W-1:0]   m_bit, seen_next, tt_next;
  logic [N_VARS:0]   count_next;

  assign dbg_state  = state;
  assign in_ready   = (state == CAPTURE);
  assign m_bit      = {{(TT_W-1){1'b0}}, 1'b1} << in_m;
  // start has priority over a sample presented in the same cycle.
  assign accept     = in_ready & in_valid & ~start;
  assign new_sample = accept & ~(|(seen_mask & m_bit));
  assign seen_next  = new_sample ? (seen_mask | m_bit) : seen_mask;
  assign tt_next    = (new_sample && in_s) ? (tt_word | m_bit) : tt_word;
  assign complete   = new_sample & (&seen_next);

  tt_popcount_update #(.N_VARS(N_VARS)) u_popcount (
    .count      (ones_count),
    .inc        (new_sample & in_s),
    .count_next (count_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: begin
        if (start)         state_next = CAPTURE;
        else if (complete) state_next = DONE;
      end
      DONE:    if (start) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tt_word    <= '0;
      seen_mask  <= '0;
      ones_count <= '0;
      done       <= 1'b0;
      match      <= 1'b0;
      dup_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        tt_word    <= '0;
        seen_mask  <= '0;
        ones_count <= '0;
        done       <= 1'b0;
        match      <= 1'b0;
        dup_err    <= 1'b0;
      end else if (accept) begin
        tt_word    <= tt_next;
        seen_mask  <= seen_next;
        ones_count <= count_next;
        // A repeat of an already-seen minterm keeps the first value.
        if (!new_sample) dup_err <= 1'b1;
        if (complete) begin
          done  <= 1'b1;
          match <= (tt_next == EXPECTED);
        end
      end
    end
  end

`ifdef TT_CAPTURE_MISMATCH_LOG_EN
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      first_bad_m   <= '0;
      first_bad_vld <= 1'b0;
    end else if (accept && !first_bad_vld && (in_s != EXPECTED[in_m])) begin
      first_bad_m   <= in_m;
      first_bad_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Downstream consumer of a 3-input combinational function stage.
- Accepts one (minterm index, function output) sample per handshake and assembles the full truth-table word.
- Counts the ones and flags completion.
- Compares the assembled word against an expected truth table, so a bench or top level can check a function such as s = (y | ~z) & (~x | ~z) without printed tables.

Parameters:
- N_VARS, 3, number of function inputs; the table has 2**N_VARS entries.
- EXPECTED, 8'h5D, expected truth-table word, bit m = f(minterm m). Default is for s = (y|~z)&(~x|~z), with x as the MSB of m.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  single-cycle pulse; clears the capture and begins a new table
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample
- in_m  input  N_VARS  minterm index {x,y,z}
- in_s  input  1  function output for in_m
- tt_word  output  2**N_VARS  captured truth table, bit m = s(m)
- seen_mask  output  2**N_VARS  bit m set once minterm m has been captured
- ones_count  output  N_VARS+1  number of set bits in tt_word (minterms with s=1)
- done  output  1  all minterms captured
- match  output  1  tt_word == EXPECTED; valid only while done=1
- dup_err  output  1  sticky; a minterm was presented twice in one capture

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: state=IDLE, tt_word=0, seen_mask=0, ones_count=0, done=0, match=0, dup_err=0, in_ready=0.
- State machine:
  - IDLE: in_ready=0. start moves to CAPTURE with all capture registers cleared.
  - CAPTURE: in_ready=1. A transfer happens on an edge where in_valid & in_ready.
    - If seen_mask[in_m]=0: set tt_word[in_m]=in_s and seen_mask[in_m]=1; increment ones_count when in_s=1.
    - If seen_mask[in_m]=1: tt_word is unchanged (first value wins) and dup_err is set. dup_err stays set until start or reset.
    - When a transfer fills the last zero bit of seen_mask, the same edge moves to DONE. done=1, and match is computed from the updated tt_word, so both are valid the cycle after the final transfer.
  - DONE: in_ready=0, outputs hold. start returns to CAPTURE with everything cleared, including done, match and dup_err.
- Latency: one cycle from transfer edge to visible tt_word / seen_mask / ones_count update.
- Boundary conditions:
  - Samples may arrive in any order; gaps with in_valid=0 are allowed.
  - start and in_valid in the same cycle: start wins, and the sample is not accepted in that cycle.
  - start during CAPTURE: restart; partial results are discarded.
  - rst_n low in any state, mid-capture included: return to reset values on that edge.
  - ones_count cannot exceed 2**N_VARS, so it never wraps.
  - in_m is always in range because its width is exactly N_VARS.

Optional Feature:
- Macro: TT_CAPTURE_MISMATCH_LOG_EN.
- When defined: adds outputs first_bad_m (N_VARS) and first_bad_vld (1).
  - On the first accepted sample with in_s != EXPECTED[in_m], latch in_m and set first_bad_vld.
  - Later mismatches do not overwrite it.
  - Both are cleared on start or reset.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2;
  - TT_WIDTH = 2**N_VARS;
  - the default expected word for the 0602 function, 8'h5D.
- Natural sub-module: tt_popcount_update, which takes the current count and an accepted-sample indication and returns the next ones_count. The FSM and registers stay in the top.

Test Plan:
- Reset, then start, then minterms 0..7 in order with s = 1,0,1,1,1,0,1,0 -> after the last transfer: tt_word=8'h5D, ones_count=5, done=1, match=1, dup_err=0.
- start, then the same samples in order 7,3,0,5,1,6,2,4 with idle gaps -> same final tt_word=8'h5D, match=1; done=0 until the 8th transfer.
- Capture with m=5 sent as s=1 -> tt_word=8'h7D, ones_count=6, match=0. With TT_CAPTURE_MISMATCH_LOG_EN: first_bad_m=5, first_bad_vld=1.
- Send m=2 (s=1) twice, the second time with s=0 -> tt_word[2] stays 1, dup_err=1, seen_mask bit 2 set once; the other 7 minterms then complete with done=1.
- After 4 transfers, assert start together with in_valid -> seen_mask=0, ones_count=0, that sample not accepted; a subsequent full capture completes normally.
- rst_n low for one edge mid-capture (3 minterms in) -> all outputs return to reset values and in_ready=0 until the next start.
